fetch_unit: RTL

Instruction fetch stage of the 16-bit single-issue core. Holds the architectural PC and issues one-outstanding requests to instruction memory. Buffers the returned instruction in a single output slot with valid/stall handshake to decode. Accepts redirects from PC_control, whose PC_out is the branch target, and stops fetching on HLT.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_slot.sv | 32 +++
 rtl/fetch_unit.sv | 74 +++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core constants for the 16-bit single-issue core: word width, reset PC,
// HLT opcode and the fetch state encoding used by fetch, PC_control and decode.
package fetch_unit_pkg;
  localparam int WORD_W = 16;
  localparam logic [3:0] HLT_OPCODE = 4'hF;
  localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt(input word_t inst);
    return inst[15:12] == HLT_OPCODE;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect from PC_control,
// and the valid/stall output slot towards decode.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  // imem: imem_req is a one-cycle pulse with imem_addr valid alongside it; the single
  // outstanding request is answered by one imem_valid pulse carrying imem_rdata.
  // decode: inst_* transfers in every cycle with inst_valid=1 and stall=0.
  logic         imem_req;
  word_t        imem_addr;
  logic         imem_valid;
  word_t        imem_rdata;
  logic         redirect_valid;
  word_t        redirect_pc;
  logic         stall;
  logic         inst_valid;
  word_t        inst_out;
  word_t        inst_pc;
  word_t        inst_pc_plus2;
  logic         halted;
  fetch_state_e state_dbg;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc_plus2,
           halted, state_dbg,
    input  imem_valid, imem_rdata, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc_plus2,
           halted, state_dbg,
    output imem_valid, imem_rdata, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_slot.sv
// Single-entry output register towards decode. Flush beats load, load beats drain,
// so a load and a drain in the same cycle keep the slot full.
module fetch_slot
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  flush,
  input  logic  stall,
  input  word_t load_inst,
  input  word_t load_pc,
  output logic  inst_valid,
  output word_t inst_out,
  output word_t inst_pc
);
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else if (flush) begin
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_valid <= 1'b1;
      inst_out   <= load_inst;
      inst_pc    <= load_pc;
    end else if (inst_valid && !stall) begin
      inst_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, keeps one imem request in flight, buffers
// the returned word for decode, follows redirects and stops fetching on HLT.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  fetch_state_e state;
  word_t        pc;
  logic         drop;
  logic         slot_ready;
  logic         issue;
  logic         resp_accept;

  assign slot_ready  = !bus.inst_valid || !bus.stall;
  assign issue       = (state == ST_ISSUE) && !bus.redirect_valid && slot_ready && !rst;
  assign resp_accept = (state == ST_WAIT) && bus.imem_valid && !drop && !bus.redirect_valid;

  assign bus.imem_req      = issue;
  assign bus.imem_addr     = pc;
  assign bus.halted        = (state == ST_HALT);
  assign bus.state_dbg     = state;
  assign bus.inst_pc_plus2 = bus.inst_pc + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ISSUE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc;
      // A request still in flight must be swallowed before the new path can issue.
      if (state == ST_WAIT && !bus.imem_valid) begin
        drop  <= 1'b1;
        state <= ST_WAIT;
      end else begin
        drop  <= 1'b0;
        state <= ST_ISSUE;
      end
    end else begin
      case (state)
        ST_ISSUE: if (issue) state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.imem_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_ISSUE;
            end else begin
              pc    <= pc + 16'd2;
              state <= is_hlt(bus.imem_rdata) ? ST_HALT : ST_ISSUE;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_ISSUE;
      endcase
    end
  end

  fetch_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (resp_accept),
    .flush      (bus.redirect_valid),
    .stall      (bus.stall),
    .load_inst  (bus.imem_rdata),
    .load_pc    (pc),
    .inst_valid (bus.inst_valid),
    .inst_out   (bus.inst_out),
    .inst_pc    (bus.inst_pc)
  );
endmodule
